// File: rtl/csa_acc_pipe_pkg.sv
// rtl/csa_acc_pipe_pkg.sv - shared widths, word/accumulator types and state encoding for csa_acc_pipe
package csa_acc_pipe_pkg;

    localparam int NBITS     = 20;
    localparam int ACC_GUARD = 8;
    localparam int W         = NBITS + ACC_GUARD;

    typedef logic [NBITS-1:0] reg_c_t;

    typedef reg_c_t [1:0]  two_word_t;
    typedef reg_c_t [3:0]  four_word_t;
    typedef reg_c_t [5:0]  six_word_t;
    typedef reg_c_t [7:0]  eight_word_t;
    typedef reg_c_t [9:0]  ten_word_t;
    typedef reg_c_t [8:0]  param9_t;
    typedef reg_c_t [24:0] param25_t;
    typedef reg_c_t [35:0] param36_t;

    typedef logic [W-1:0] acc_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/csa_acc_pipe_csa_row.sv
// rtl/csa_acc_pipe_csa_row.sv - csa_row: WIDTH-bit 3:2 compressor row, carry pre-shifted to its weight
module csa_row #(
    parameter int WIDTH = 28
) (
    input  logic [WIDTH-1:0] a,      // operand
    input  logic [WIDTH-1:0] b,      // operand
    input  logic [WIDTH-1:0] c,      // operand
    output logic [WIDTH-1:0] sum,    // bitwise sum
    output logic [WIDTH-1:0] carry   // majority, shifted left one place (MSB carry dropped, mod 2^WIDTH)
);

    logic [WIDTH-1:0] maj;

    always_comb begin
        sum   = a ^ b ^ c;
        maj   = (a & b) | (a & c) | (b & c);
        carry = maj << 1;
    end

endmodule

// File: rtl/csa_acc_pipe.sv
// rtl/csa_acc_pipe.sv - carry-save frame accumulator, 2-stage output pipe; CSA_SAT_EN selects saturating out_sum
module csa_acc_pipe #(
    parameter int NBITS     = 20,
    parameter int NWORDS    = 9,
    parameter int ACC_GUARD = 8
) (
    input  logic                          clock,      // rising-edge clock
    input  logic                          reset,      // synchronous, active-high
    input  logic                          in_valid,   // beat present
    output logic                          in_ready,   // beat accepted when in_valid && in_ready
    input  logic [NWORDS-1:0][NBITS-1:0]  in_words,   // signed words of the beat
    input  logic                          in_first,   // beat opens a frame
    input  logic                          in_last,    // beat closes a frame
    output logic                          out_valid,  // result held
    input  logic                          out_ready,  // consumer takes result
    output logic [NBITS-1:0]              out_sum,    // frame sum
    output logic                          out_ovf,    // sum outside signed NBITS range
    output logic [15:0]                   out_count   // accepted beats in frame, saturating
);

    import csa_acc_pipe_pkg::*;

    localparam int ACC_W = NBITS + ACC_GUARD;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_s_q, acc_s_d, acc_c_q, acc_c_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [ACC_W-1:0]   done_s_q, done_s_d, done_c_q, done_c_d;
    logic [15:0]        done_cnt_q, done_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [NBITS-1:0]   out_sum_q, out_sum_d;
    logic               out_ovf_q, out_ovf_d;
    logic [15:0]        out_cnt_q, out_cnt_d;

    logic               out_accept;
    logic               beat_acc;
    logic               restart;
    logic [15:0]        beat_cnt;
    logic [ACC_W-1:0]   s_chain [NWORDS+1];
    logic [ACC_W-1:0]   c_chain [NWORDS+1];
    logic [ACC_W-1:0]   final_sum;
    logic [ACC_W-NBITS:0] sum_hi;
    logic               sum_ovf;
    logic [NBITS-1:0]   sum_out;

    assign out_accept = !out_valid_q || out_ready;
    // Only a stalled done stage blocks input; a transfer frees it in the same cycle.
    assign in_ready   = !(done_q && !out_accept);
    assign beat_acc   = in_valid && in_ready;
    assign restart    = in_first || (state_q == ST_IDLE);
    assign beat_cnt   = restart ? 16'd1 : ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1);

    assign s_chain[0] = restart ? '0 : acc_s_q;
    assign c_chain[0] = restart ? '0 : acc_c_q;

    // Each row folds one sign-extended word into the running (sum, carry) pair.
    for (genvar i = 0; i < NWORDS; i++) begin : g_tree
        logic [ACC_W-1:0] word_ext;
        assign word_ext = {{ACC_GUARD{in_words[i][NBITS-1]}}, in_words[i]};
        csa_row #(.WIDTH(ACC_W)) u_row (
            .a     (s_chain[i]),
            .b     (c_chain[i]),
            .c     (word_ext),
            .sum   (s_chain[i+1]),
            .carry (c_chain[i+1])
        );
    end

    assign final_sum = done_s_q + done_c_q;
    // In range iff every bit from the NBITS sign bit upward agrees.
    assign sum_hi    = final_sum[ACC_W-1:NBITS-1];
    assign sum_ovf   = !((&sum_hi) || !(|sum_hi));

`ifdef CSA_SAT_EN
    assign sum_out = !sum_ovf ? final_sum[NBITS-1:0]
                   : (final_sum[ACC_W-1] ? {1'b1, {(NBITS-1){1'b0}}} : {1'b0, {(NBITS-1){1'b1}}});
`else
    assign sum_out = final_sum[NBITS-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        acc_s_d     = acc_s_q;
        acc_c_d     = acc_c_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        done_s_d    = done_s_q;
        done_c_d    = done_c_q;
        done_cnt_d  = done_cnt_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        out_cnt_d   = out_cnt_q;

        if (out_accept) begin
            out_valid_d = done_q;
            done_d      = 1'b0;
            if (done_q) begin
                out_sum_d = sum_out;
                out_ovf_d = sum_ovf;
                out_cnt_d = done_cnt_q;
            end
        end

        if (beat_acc) begin
            if (in_last) begin
                state_d    = ST_IDLE;
                acc_s_d    = '0;
                acc_c_d    = '0;
                cnt_d      = '0;
                done_d     = 1'b1;
                done_s_d   = s_chain[NWORDS];
                done_c_d   = c_chain[NWORDS];
                done_cnt_d = beat_cnt;
            end else begin
                state_d    = ST_ACC;
                acc_s_d    = s_chain[NWORDS];
                acc_c_d    = c_chain[NWORDS];
                cnt_d      = beat_cnt;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_s_q     <= '0;
            acc_c_q     <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            done_s_q    <= '0;
            done_c_q    <= '0;
            done_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_s_q     <= acc_s_d;
            acc_c_q     <= acc_c_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            done_s_q    <= done_s_d;
            done_c_q    <= done_c_d;
            done_cnt_q  <= done_cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign out_count = out_cnt_q;

endmodule

// File: tb/tb_csa_acc_pipe.sv
// tb/tb_csa_acc_pipe.sv - self-checking bench for csa_acc_pipe with frame-level reference model
module tb_csa_acc_pipe;

    localparam int NB = 20;
    localparam int NW = 9;
    localparam int WW = 28;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [NW-1:0][NB-1:0]  in_words;
    logic                   in_first;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [NB-1:0]          out_sum;
    logic                   out_ovf;
    logic [15:0]            out_count;

    csa_acc_pipe #(.NBITS(NB), .NWORDS(NW), .ACC_GUARD(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_words  (in_words),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [NB-1:0] sum;
        logic          ovf;
        logic [15:0]   cnt;
    } res_t;

    res_t          exp_q[$];
    longint        m_sum;
    int            m_cnt;
    bit            m_open;
    bit            rand_ready;
    int            n_checks;
    int            n_fail;
    logic [NB-1:0] words_v [NW];

    function automatic longint sx(input logic [NB-1:0] w);
        longint v;
        v = longint'(w);
        if (w[NB-1]) v = v - (longint'(1) << NB);
        return v;
    endfunction

    function automatic longint wrap_w(input longint v);
        longint m;
        m = v & ((longint'(1) << WW) - 1);
        if (m >= (longint'(1) << (WW-1))) m = m - (longint'(1) << WW);
        return m;
    endfunction

    function automatic res_t make_res(input longint s, input int c);
        res_t   r;
        longint maxv;
        longint minv;
        maxv  = (longint'(1) << (NB-1)) - 1;
        minv  = -(longint'(1) << (NB-1));
        r.ovf = (s > maxv) || (s < minv);
`ifdef CSA_SAT_EN
        if (s > maxv)      r.sum = maxv[NB-1:0];
        else if (s < minv) r.sum = minv[NB-1:0];
        else               r.sum = s[NB-1:0];
`else
        r.sum = s[NB-1:0];
`endif
        r.cnt = (c > 65535) ? 16'hFFFF : 16'(c);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_accept();
        if (in_first || !m_open) begin
            m_sum = 0;
            m_cnt = 0;
        end
        for (int i = 0; i < NW; i++) m_sum = wrap_w(m_sum + sx(in_words[i]));
        m_cnt++;
        if (in_last) begin
            exp_q.push_back(make_res(m_sum, m_cnt));
            m_open = 0;
        end else begin
            m_open = 1;
        end
    endtask

    // Called just after a falling edge with inputs set; covers the next rising edge.
    task automatic step(output bit accepted);
        res_t e;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected: observed result 0x%0h expected none", out_sum);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_sum", 32'(out_sum), 32'(e.sum));
                check("sb_ovf", 32'(out_ovf), 32'(e.ovf));
                check("sb_cnt", 32'(out_count), 32'(e.cnt));
            end
        end
        if (accepted) model_accept();
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        bit dummy;
        in_valid = 1'b0;
        repeat (n) step(dummy);
    endtask

    task automatic fill(input logic [NB-1:0] v);
        for (int i = 0; i < NW; i++) words_v[i] = v;
    endtask

    task automatic send_beat(input bit first, input bit last);
        bit acc;
        int tries;
        acc   = 0;
        tries = 0;
        for (int i = 0; i < NW; i++) in_words[i] = words_v[i];
        in_first = first;
        in_last  = last;
        in_valid = 1'b1;
        while (!acc && tries < 64) begin
            step(acc);
            tries++;
        end
        check("beat_accepted", 32'(acc), 32'd1);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        bit acc;
        int len;
        int guard;
        logic [31:0] r;
        n_checks   = 0;
        n_fail     = 0;
        m_open     = 0;
        m_sum      = 0;
        m_cnt      = 0;
        rand_ready = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_first   = 1'b0;
        in_last    = 1'b0;
        in_words   = '0;
        out_ready  = 1'b1;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        @(negedge clock);
        check("rst_in_ready_c1", 32'(in_ready), 32'd1);

        // Single beat of ones
        fill(20'd1);
        send_beat(1, 1);
        check("ones_valid_e1", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        step(acc);
        check("ones_valid_e2", 32'(out_valid), 32'd1);
        check("ones_sum",      32'(out_sum),   32'd9);
        check("ones_count",    32'(out_count), 32'd1);
        check("ones_ovf",      32'(out_ovf),   32'd0);
        out_ready = 1'b1;
        step(acc);

        // Three beats of -1
        fill(20'hFFFFF);
        send_beat(1, 0);
        send_beat(0, 0);
        send_beat(0, 1);
        out_ready = 1'b0;
        step(acc);
        check("neg_sum",   32'(out_sum),   32'h000FFFE5);
        check("neg_count", 32'(out_count), 32'd3);
        check("neg_ovf",   32'(out_ovf),   32'd0);
        out_ready = 1'b1;
        step(acc);

        // Positive overflow
        fill(20'h7FFFF);
        send_beat(1, 1);
        out_ready = 1'b0;
        step(acc);
        check("ovf_flag", 32'(out_ovf), 32'd1);
`ifdef CSA_SAT_EN
        check("ovf_sum", 32'(out_sum), 32'h0007FFFF);
`else
        check("ovf_sum", 32'(out_sum), 32'h0007FFF7);
`endif
        out_ready = 1'b1;
        step(acc);

        // Abort by new first
        fill(20'd5);
        send_beat(1, 0);
        fill(20'd2);
        send_beat(1, 1);
        out_ready = 1'b0;
        step(acc);
        check("abort_sum",   32'(out_sum),   32'd18);
        check("abort_count", 32'(out_count), 32'd1);
        out_ready = 1'b1;
        step(acc);
        idle(2);

        // Backpressure: result held plus a second result in the done stage
        out_ready = 1'b0;
        fill(20'd3);
        send_beat(1, 1);
        idle(2);
        fill(20'hFFFFE);
        send_beat(1, 1);
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_held_sum", 32'(out_sum),  32'd27);
        @(negedge clock);
        fill(20'd1);
        for (int i = 0; i < NW; i++) in_words[i] = words_v[i];
        in_first = 1'b1;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(acc);
            check("bp_stall_acc", 32'(acc),     32'd0);
            check("bp_stable",    32'(out_sum), 32'd27);
        end
        out_ready = 1'b1;
        send_beat(1, 1);
        idle(4);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Long frame wrapping modulo 2^W
        fill(20'h7FFFF);
        send_beat(1, 0);
        for (int b = 1; b < 39; b++) send_beat(0, 0);
        send_beat(0, 1);
        idle(3);

        // Reset with an open frame and a held result
        out_ready = 1'b0;
        fill(20'd4);
        send_beat(1, 1);
        idle(2);
        send_beat(1, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        m_open    = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rst_mid_no_valid", 32'(out_valid), 32'd0);
            @(negedge clock);
        end
        fill(20'd1);
        send_beat(0, 1);
        idle(3);

        // Randomized frames with random backpressure
        rand_ready = 1;
        for (int f = 0; f < 150; f++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                for (int i = 0; i < NW; i++) begin
                    r = $urandom;
                    if (r[31]) words_v[i] = r[NB-1:0];
                    else       words_v[i] = {{(NB-4){r[3]}}, r[3:0]};
                end
                send_beat((b == 0) || ($urandom_range(0, 15) == 0), b == len - 1);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_ready = 0;
        out_ready  = 1'b1;
        guard      = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            idle(1);
            guard++;
        end
        idle(2);
        check("final_drained",   32'(exp_q.size()), 32'd0);
        check("final_out_valid", 32'(out_valid),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csa_acc_pipe.md
CSA_ACC_PIPE -- requirements
Module: csa_acc_pipe

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter NBITS SHALL default to 20 and set the input word and result width.
REQ-003 Parameter NWORDS SHALL default to 9, be legal from 2 to 36, and set the number of words reduced per beat.
REQ-004 Parameter ACC_GUARD SHALL default to 8 and set the number of internal guard bits; internal width W = NBITS+ACC_GUARD.
REQ-005 Port clock, input, 1 bit: rising-edge clock.
REQ-006 Port reset, input, 1 bit: synchronous active-high reset.
REQ-007 Port in_valid, input, 1 bit: beat present.
REQ-008 Port in_ready, output, 1 bit: beat accepted when in_valid and in_ready are both high.
REQ-009 Port in_words, input, NWORDS x NBITS: packed array of signed two's-complement words.
REQ-010 Port in_first, input, 1 bit: beat opens a frame.
REQ-011 Port in_last, input, 1 bit: beat closes a frame.
REQ-012 Port out_valid, output, 1 bit: result held.
REQ-013 Port out_ready, input, 1 bit: consumer takes the result when out_valid and out_ready are both high.
REQ-014 Port out_sum, output, NBITS: frame sum.
REQ-015 Port out_ovf, output, 1 bit: frame sum outside the signed NBITS range.
REQ-016 Port out_count, output, 16 bits: accepted beats in the frame, saturating at 0xFFFF.

Function
REQ-017 The accumulator SHALL be held in carry-save form (acc_s, acc_c, each W bits); each accepted beat SHALL reduce NWORDS sign-extended words plus acc_s/acc_c to a new pair through a 3:2 CSA tree in one cycle, with no carry-propagate add.
REQ-018 The block SHALL have two states, IDLE (no open frame) and ACC (frame open); an accepted beat with in_last high SHALL move the state to IDLE, and an accepted beat without in_last SHALL move it to ACC.
REQ-019 An accepted beat with in_first high, or any accepted beat in IDLE, SHALL use zero in place of acc_s/acc_c and SHALL restart the beat count at 1.
REQ-020 An in_first beat accepted in ACC SHALL silently discard the open frame (abort).
REQ-021 An accepted in_last beat SHALL write the reduced pair and beat count into the done stage (done_q=1) and SHALL clear the accumulator.
REQ-022 Stage 2 SHALL perform the final W-bit carry-propagate add from done_q into the output register, with out_valid rising 2 clock edges after the accepting edge of the last beat.
REQ-023 out_ovf SHALL be 1 when the W-bit sum is less than -2^(NBITS-1) or greater than 2^(NBITS-1)-1.
REQ-024 Frames exceeding 2^ACC_GUARD/NWORDS beats SHALL wrap modulo 2^W, and this SHALL NOT be flagged.
REQ-025 The output register SHALL load when out_valid is 0 or out_ready is 1 (out_accept); out_sum, out_ovf and out_count SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 in_ready SHALL be 0 exactly when done_q=1 and out_accept=0; done_q transfer and a new last beat in the same cycle SHALL both complete, giving sustained throughput of 1 single-beat frame per cycle.

Reset
REQ-027 On reset, out_valid, done_q, out_ovf, out_sum, out_count, acc_s and acc_c SHALL be 0, the state SHALL be IDLE, and in_ready SHALL be 1 from the first cycle after reset.
REQ-028 Reset asserted mid-frame or with a result held SHALL discard all in-flight data, and no out_valid SHALL follow.

Configuration
REQ-029 With macro CSA_SAT_EN defined, out_sum SHALL clamp to 2^(NBITS-1)-1 or -2^(NBITS-1) on overflow.
REQ-030 With CSA_SAT_EN undefined, out_sum SHALL be the low NBITS bits of the W-bit sum (wrap-around).
REQ-031 out_ovf SHALL be reported both with and without CSA_SAT_EN.

Structure
REQ-032 The shared package SHALL hold NBITS, ACC_GUARD, the regC word type, the existing two/four/six/eight/ten-word and param9/25/36 types, and a W-bit accumulator type.
REQ-033 One sub-module, csa_row, SHALL implement a parametrised-width 3:2 compressor row, instantiated in a generate loop to build the tree.

Verification
REQ-034 The bench SHALL check that reset is held 3 cycles and then released -> out_valid=0, in_ready=1, out_sum=0.
REQ-035 The bench SHALL check that one beat with first and last high and all 9 words = 1 -> out_sum=9, out_count=1, out_ovf=0, out_valid exactly 2 edges after acceptance.
REQ-036 The bench SHALL check that 3 beats with all words = 0xFFFFF (-1) -> out_sum=0xFFFE5 (-27), out_count=3.
REQ-037 The bench SHALL check that one beat with all words = 0x7FFFF -> out_ovf=1; out_sum=0x7FFFF with CSA_SAT_EN, 0x7FFF7 without.
REQ-038 The bench SHALL check that with out_ready=0 and a result held, a second frame's last beat -> in_ready=0 and out_sum stable; out_ready=1 -> both results delivered in order.
REQ-039 The bench SHALL check that first(words=5), then first+last(words=2) -> single result 18, out_count=1.
